// File: rtl/gp22_pkg.sv
// Shared definitions for the GP22 TDC serial-interface emulator: FSM state
// encodings, opcode constants and frame lengths.
package gp22_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_OPC  = 3'd1;
    localparam logic [2:0] ST_WR   = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_IGN  = 3'd4;

    localparam logic [7:0] OPC_WR            = 8'h80;
    localparam logic [7:0] OPC_RD            = 8'hB0;
    localparam logic [7:0] OPC_POR           = 8'h50;
    localparam logic [7:0] OPC_INIT          = 8'h70;
    localparam logic [7:0] OPC_START_TOF     = 8'h01;
    localparam logic [7:0] OPC_START_TEMP    = 8'h02;
    localparam logic [7:0] OPC_START_CAL_RES = 8'h03;
    localparam logic [7:0] OPC_START_CAL_TDC = 8'h04;

    localparam int unsigned OPC_BITS  = 8;
    localparam int unsigned DATA_BITS = 32;

    function automatic logic is_cmd(input logic [7:0] opc);
        return (opc == OPC_POR) || (opc == OPC_INIT) || (opc == OPC_START_TOF) ||
               (opc == OPC_START_TEMP) || (opc == OPC_START_CAL_RES) ||
               (opc == OPC_START_CAL_TDC);
    endfunction

endpackage

// File: rtl/gp22_spi_sync.sv
// Synchroniser for SCK/SSN/SI with SCK-fall and SSN-rise edge detection.
module gp22_spi_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_i,
    input  logic ssn_i,
    input  logic si_i,
    output logic ssn_o,
    output logic si_o,
    output logic sck_fall_o,
    output logic ssn_rise_o
);

    logic [SYNC_STAGES-1:0] sck_q, ssn_q, si_q;
    logic                   sck_prev_q, ssn_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q      <= '0;
            ssn_q      <= '1;
            si_q       <= '0;
            sck_prev_q <= 1'b0;
            ssn_prev_q <= 1'b1;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
            ssn_q      <= {ssn_q[SYNC_STAGES-2:0], ssn_i};
            si_q       <= {si_q[SYNC_STAGES-2:0], si_i};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
            ssn_prev_q <= ssn_q[SYNC_STAGES-1];
        end
    end

    assign ssn_o      = ssn_q[SYNC_STAGES-1];
    assign si_o       = si_q[SYNC_STAGES-1];
    assign sck_fall_o = sck_prev_q & ~sck_q[SYNC_STAGES-1];
    assign ssn_rise_o = ~ssn_prev_q & ssn_q[SYNC_STAGES-1];

endmodule

// File: rtl/gp22_spi_slave.sv
// GP22 TDC SPI target: config register bank, result/status reads, command pulses.
// Define GP22_SLV_RDBACK_EN to make read address 5 return register 1 bits 31:24.
module gp22_spi_slave
    import gp22_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CFG_REGS    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         SPI_SCK,
    input  logic         SPI_SSN,
    input  logic         SPI_SI,
    output logic         SPI_SO,
    input  logic [127:0] i_result,
    input  logic [15:0]  i_status,
    output logic [255:0] o_cfg,
    output logic         o_cfg_wr,
    output logic [2:0]   o_cfg_addr,
    output logic         o_cmd_pulse,
    output logic [7:0]   o_cmd_code
);

    localparam logic [1:0] FLUSH_CNT = 2'(SYNC_STAGES);
    localparam logic [4:0] OPC_LAST  = 5'(OPC_BITS - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);

    logic ssn_s, si_s, sck_fall, ssn_rise;

    gp22_spi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck_i     (SPI_SCK),
        .ssn_i     (SPI_SSN),
        .si_i      (SPI_SI),
        .ssn_o     (ssn_s),
        .si_o      (si_s),
        .sck_fall_o(sck_fall),
        .ssn_rise_o(ssn_rise)
    );

    logic [2:0]                 state_q, state_d;
    logic [4:0]                 bit_cnt_q, bit_cnt_d;
    logic [30:0]                shreg_q, shreg_d;
    logic [2:0]                 addr_q, addr_d;
    logic                       so_q, so_d;
    logic [CFG_REGS-1:0][31:0]  cfg_q, cfg_d;
    logic                       cfg_wr_q, cfg_wr_d;
    logic [2:0]                 cfg_addr_q, cfg_addr_d;
    logic                       cmd_pulse_q, cmd_pulse_d;
    logic [7:0]                 cmd_code_q, cmd_code_d;
    logic [1:0]                 flush_q, flush_d;
    logic                       armed_q, armed_d;
    logic                       flush_done;

    logic [7:0]  opcode;
    logic [31:0] wr_data;
    logic [31:0] rd_word;

    assign opcode  = {shreg_q[6:0], si_s};
    assign wr_data = {shreg_q[30:0], si_s};

    // A frame may only start once SSN has been seen high after reset, so a
    // reset released mid-frame does not pick up the tail of that frame.
    assign flush_done = (flush_q == FLUSH_CNT);
    assign flush_d    = flush_done ? flush_q : flush_q + 2'd1;
    assign armed_d    = armed_q | (flush_done & ssn_s);

    always_comb begin
        rd_word = 32'd0;
        case (opcode[2:0])
            3'd0: rd_word = i_result[31:0];
            3'd1: rd_word = i_result[63:32];
            3'd2: rd_word = i_result[95:64];
            3'd3: rd_word = i_result[127:96];
            3'd4: rd_word = {16'd0, i_status};
`ifdef GP22_SLV_RDBACK_EN
            3'd5: rd_word = {cfg_q[1][31:24], 24'd0};
`else
            3'd5: rd_word = 32'd0;
`endif
            3'd6: rd_word = cfg_q[6];
            3'd7: rd_word = cfg_q[7];
            default: rd_word = 32'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        addr_d      = addr_q;
        so_d        = so_q;
        cfg_d       = cfg_q;
        cfg_wr_d    = 1'b0;
        cfg_addr_d  = cfg_addr_q;
        cmd_pulse_d = 1'b0;
        cmd_code_d  = cmd_code_q;

        case (state_q)
            ST_IDLE: begin
                so_d = 1'b0;
                if (armed_q && !ssn_s) begin
                    state_d   = ST_OPC;
                    bit_cnt_d = 5'd0;
                end
            end
            ST_OPC: begin
                if (sck_fall) begin
                    shreg_d   = {shreg_q[29:0], si_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == OPC_LAST) begin
                        bit_cnt_d = 5'd0;
                        addr_d    = opcode[2:0];
                        if (opcode[7:3] == OPC_WR[7:3]) begin
                            state_d = ST_WR;
                        end else if (opcode[7:3] == OPC_RD[7:3]) begin
                            so_d    = rd_word[31];
                            shreg_d = rd_word[30:0];
                            state_d = ST_RD;
                        end else if (is_cmd(opcode)) begin
                            cmd_pulse_d = 1'b1;
                            cmd_code_d  = opcode;
                            if (opcode == OPC_POR) begin
                                cfg_d = '0;
                            end
                            state_d = ST_IGN;
                        end else begin
                            state_d = ST_IGN;
                        end
                    end
                end
            end
            ST_WR: begin
                if (sck_fall) begin
                    shreg_d   = wr_data[30:0];
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == DATA_LAST) begin
                        cfg_d[addr_q] = wr_data;
                        cfg_wr_d      = 1'b1;
                        cfg_addr_d    = addr_q;
                        state_d       = ST_IGN;
                    end
                end
            end
            ST_RD: begin
                if (sck_fall) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        so_d    = 1'b0;
                        state_d = ST_IGN;
                    end else begin
                        so_d      = shreg_q[30];
                        shreg_d   = {shreg_q[29:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_IGN: so_d = 1'b0;
            default: begin
                so_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        // End of frame wins over state, but any commit above still lands.
        if (ssn_rise) begin
            state_d = ST_IDLE;
            so_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            shreg_q     <= '0;
            addr_q      <= 3'd0;
            so_q        <= 1'b0;
            cfg_q       <= '0;
            cfg_wr_q    <= 1'b0;
            cfg_addr_q  <= 3'd0;
            cmd_pulse_q <= 1'b0;
            cmd_code_q  <= 8'd0;
            flush_q     <= 2'd0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            addr_q      <= addr_d;
            so_q        <= so_d;
            cfg_q       <= cfg_d;
            cfg_wr_q    <= cfg_wr_d;
            cfg_addr_q  <= cfg_addr_d;
            cmd_pulse_q <= cmd_pulse_d;
            cmd_code_q  <= cmd_code_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
        end
    end

    assign SPI_SO      = so_q;
    assign o_cfg       = cfg_q;
    assign o_cfg_wr    = cfg_wr_q;
    assign o_cfg_addr  = cfg_addr_q;
    assign o_cmd_pulse = cmd_pulse_q;
    assign o_cmd_code  = cmd_code_q;

endmodule
